// File: rtl/huffman_feed_ctrl_if.sv
// Word, decoder-bit, decoder-symbol and symbol-output handshakes of huffman_feed_ctrl.
// master: the controller; slave: the surrounding upstream/decoder/consumer side.
interface huffman_feed_ctrl_if #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic              dec_bit;
    logic              dec_bit_valid;
    logic [3:0]        dec_out;
    logic              dec_out_ready;
    logic [3:0]        sym_out;
    logic              sym_valid;
    logic              sym_ready;

    modport master (
        input  word_in, word_valid, dec_out, dec_out_ready, sym_ready,
        output word_ready, dec_bit, dec_bit_valid, sym_out, sym_valid
    );

    modport slave (
        output word_in, word_valid, dec_out, dec_out_ready, sym_ready,
        input  word_ready, dec_bit, dec_bit_valid, sym_out, sym_valid
    );
endinterface

// File: rtl/huffman_feed_ctrl.sv
// Frame sequencer: serializes code words into the Huffman decoder and buffers its symbols.
// Define HUFF_FEED_STATS_EN to add the stat_bits / stat_stall frame counters.
module huffman_feed_ctrl #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DEC_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cfg_sym_count,
    output logic        busy,
    output logic        done,
    output logic        ovf_err,
`ifdef HUFF_FEED_STATS_EN
    output logic [31:0] stat_bits,
    output logic [31:0] stat_stall,
`endif
    huffman_feed_ctrl_if.master bus
);
    localparam int unsigned BIT_W    = $clog2(WORD_W + 1);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DRN_W    = $clog2(DEC_LAT + 2);
    localparam int unsigned STALL_AT = FIFO_DEPTH - DEC_LAT - 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DRAIN, S_DONE} state_t;

    state_t             state;
    logic [15:0]        sym_left;
    logic [BIT_W-1:0]   bit_left;
    logic [WORD_W-1:0]  shreg;
    logic [DRN_W-1:0]   drain_cnt;
    logic [3:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   fifo_cnt;

    logic               capture;
    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               last_sym;
    logic               stall;
    logic               head_from_in;
    logic [PTR_W-1:0]   rd_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    // Capture/push/pop strobes; a pop frees the slot for a same-cycle push even when full.
    always_comb begin
        capture      = (state != S_IDLE) && bus.dec_out_ready && (sym_left != 16'd0);
        fifo_full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
        pop          = bus.sym_valid && bus.sym_ready;
        push         = capture && (!fifo_full || pop);
        last_sym     = capture && (sym_left == 16'd1);
        stall        = (fifo_cnt >= CNT_W'(STALL_AT));
        head_from_in = push && (fifo_cnt == CNT_W'(pop));
        rd_nxt       = rd_ptr + PTR_W'(pop);
        cnt_nxt      = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.dec_out;
    end

    // Registered FIFO head; a push into an (effectively) empty FIFO bypasses the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_cnt      <= '0;
            bus.sym_valid <= 1'b0;
            bus.sym_out   <= 4'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr        <= rd_nxt;
            fifo_cnt      <= cnt_nxt;
            bus.sym_valid <= (cnt_nxt != '0);
            if (head_from_in)        bus.sym_out <= bus.dec_out;
            else if (cnt_nxt != '0)  bus.sym_out <= mem[rd_nxt];
        end
    end

    // Frame FSM; the last counted symbol ends the frame and discards unshifted bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_IDLE;
            sym_left          <= 16'd0;
            bit_left          <= '0;
            shreg             <= '0;
            drain_cnt         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            ovf_err           <= 1'b0;
            bus.word_ready    <= 1'b0;
            bus.dec_bit       <= 1'b0;
            bus.dec_bit_valid <= 1'b0;
`ifdef HUFF_FEED_STATS_EN
            stat_bits         <= 32'd0;
            stat_stall        <= 32'd0;
`endif
        end else begin
            done              <= 1'b0;
            bus.dec_bit_valid <= 1'b0;
            if (capture) sym_left <= sym_left - 16'd1;
            if (capture && fifo_full && !pop) ovf_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        sym_left <= cfg_sym_count;
                        ovf_err  <= 1'b0;
                        busy     <= 1'b1;
`ifdef HUFF_FEED_STATS_EN
                        stat_bits  <= 32'd0;
                        stat_stall <= 32'd0;
`endif
                        if (cfg_sym_count == 16'd0) begin
                            state <= S_DONE;
                        end else begin
                            state          <= S_LOAD;
                            bus.word_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (last_sym) begin
                        state          <= S_DRAIN;
                        bus.word_ready <= 1'b0;
                        drain_cnt      <= DRN_W'(DEC_LAT);
                    end else if (bus.word_valid && bus.word_ready) begin
                        shreg          <= bus.word_in;
                        bit_left       <= BIT_W'(WORD_W);
                        bus.word_ready <= 1'b0;
                        state          <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (last_sym) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRN_W'(DEC_LAT);
                    end else if (stall) begin
`ifdef HUFF_FEED_STATS_EN
                        if (stat_stall != 32'hFFFF_FFFF) stat_stall <= stat_stall + 32'd1;
`endif
                    end else begin
                        bus.dec_bit       <= shreg[WORD_W-1];
                        bus.dec_bit_valid <= 1'b1;
                        shreg             <= {shreg[WORD_W-2:0], 1'b0};
                        bit_left          <= bit_left - BIT_W'(1);
`ifdef HUFF_FEED_STATS_EN
                        if (stat_bits != 32'hFFFF_FFFF) stat_bits <= stat_bits + 32'd1;
`endif
                        if (bit_left == BIT_W'(1)) begin
                            state          <= S_LOAD;
                            bus.word_ready <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt != '0)         drain_cnt <= drain_cnt - DRN_W'(1);
                    else if (fifo_cnt == '0)     state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
